// File: rtl/hft_pkg.sv
// Shared order-book types: order message layout, order types and scheduler enums.
// Also used by the order book itself, so field layout changes ripple there too.
package hft_pkg;

  localparam int PRICE_W = 32;
  localparam int QTY_W   = 16;
  localparam int ID_W    = 32;
  localparam int STOCK_W = 2;

  typedef enum logic [1:0] {
    ADD     = 2'd0,
    CANCEL  = 2'd1,
    EXECUTE = 2'd2
  } order_t;

  localparam logic [1:0] ORDER_INVALID = 2'd3;

  typedef struct packed {
    logic [STOCK_W-1:0] stock_id;
    order_t             order_type;
    logic [QTY_W-1:0]   quantity;
    logic [PRICE_W-1:0] price;
    logic [ID_W-1:0]    order_id;
  } order_msg_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GRANT = 2'd3
  } sched_state_t;

  typedef enum logic {
    SERVE_CMD  = 1'b0,
    SERVE_READ = 1'b1
  } serve_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head; pushes when full and
// pops when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign o_full  = (count_q == (AW+1)'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_data  = mem_q[rd_ptr_q];

  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_data;
  end

endmodule

// File: rtl/order_book_scheduler.sv
// Sequences feed commands into the order book and round-robin read grants,
// alternating fairly between the two whenever both are pending.
module order_book_scheduler
  import hft_pkg::*;
#(
  parameter int NUM_STOCKS = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_msg_valid,
  output logic                  o_msg_ready,
  input  logic [STOCK_W-1:0]    i_stock_id,
  input  logic [1:0]            i_order_type,
  input  logic [QTY_W-1:0]      i_quantity,
  input  logic [PRICE_W-1:0]    i_price,
  input  logic [ID_W-1:0]       i_order_id,
  output logic                  o_bk_valid,
  output logic [STOCK_W-1:0]    o_bk_stock_id,
  output logic [1:0]            o_bk_order_type,
  output logic [QTY_W-1:0]      o_bk_quantity,
  output logic [PRICE_W-1:0]    o_bk_price,
  output logic [ID_W-1:0]       o_bk_order_id,
  input  logic                  i_bk_busy,
  input  logic                  i_bk_data_valid,
  input  logic [NUM_STOCKS-1:0] i_rd_req,
  output logic [NUM_STOCKS-1:0] o_rd_grant,
  output logic                  o_idle,
  output logic [7:0]            o_drop_count,
  output logic                  o_error
);

  localparam int PTR_W = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1;
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int MSG_W = $bits(order_msg_t);

  sched_state_t          state_q, state_d;
  serve_t                last_q, last_d;
  logic [PTR_W-1:0]      rr_q, rr_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic                  bk_valid_q, bk_valid_d;
  order_msg_t            bk_msg_q, bk_msg_d;
  logic [NUM_STOCKS-1:0] grant_q, grant_d;
  logic [7:0]            drop_q, drop_d;
  logic                  error_q, error_d;
  logic                  idle_q, idle_d;

  order_msg_t            in_msg, fifo_head;
  logic [MSG_W-1:0]      fifo_head_raw;
  logic                  fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count, fifo_count_next;
  logic                  accept, push, pop, drop;
  logic                  any_req, issue_go, grant_go, timeout_hit;
  logic [NUM_STOCKS-1:0] grant_vec;
  logic [PTR_W-1:0]      grant_idx, rr_next;

  assign o_msg_ready = i_reset_n && !fifo_full;
  assign accept      = i_msg_valid && o_msg_ready;
  assign drop        = accept && (i_order_type == ORDER_INVALID);
  assign push        = accept && (i_order_type != ORDER_INVALID);
  assign in_msg      = '{i_stock_id, order_t'(i_order_type), i_quantity, i_price, i_order_id};
  assign fifo_head   = order_msg_t'(fifo_head_raw);
  assign any_req     = |i_rd_req;

  sync_fifo #(
    .WIDTH (MSG_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_push    (push),
    .i_data    (in_msg),
    .i_pop     (pop),
    .o_data    (fifo_head_raw),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty),
    .o_count   (fifo_count)
  );

  // Round-robin pick: first live request at or after rr_q, wrapping.
  always_comb begin
    logic             found;
    logic [PTR_W-1:0] idx;
    grant_vec = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int i = 0; i < NUM_STOCKS; i++) begin
      idx = PTR_W'((int'(rr_q) + i) % NUM_STOCKS);
      if (!found && i_rd_req[idx]) begin
        found          = 1'b1;
        grant_vec[idx] = 1'b1;
        grant_idx      = idx;
      end
    end
    rr_next = PTR_W'((int'(grant_idx) + 1) % NUM_STOCKS);
  end

  assign timeout_hit = (state_q == ST_WAIT) && !i_bk_data_valid &&
                       (timer_q == TMR_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!i_bk_busy) begin
          if (!fifo_empty && (!any_req || last_q == SERVE_READ)) state_d = ST_ISSUE;
          else if (any_req)                                    state_d = ST_GRANT;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (i_bk_data_valid || timeout_hit) state_d = ST_IDLE;
      ST_GRANT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Command and grant registers load on the decision edge so they are
  // visible during the ISSUE / GRANT cycle itself.
  always_comb begin
    issue_go        = (state_q == ST_IDLE) && (state_d == ST_ISSUE);
    grant_go        = (state_q == ST_IDLE) && (state_d == ST_GRANT);
    pop             = issue_go;
    bk_valid_d      = issue_go;
    bk_msg_d        = issue_go ? fifo_head : bk_msg_q;
    grant_d         = grant_go ? grant_vec : '0;
    rr_d            = grant_go ? rr_next : rr_q;
    last_d          = issue_go ? SERVE_CMD : (grant_go ? SERVE_READ : last_q);
    timer_d         = timer_q;
    if (state_q == ST_ISSUE)     timer_d = '0;
    else if (state_q == ST_WAIT) timer_d = timer_q + TMR_W'(1);
    error_d         = error_q | timeout_hit;
    drop_d          = drop ? sat_inc8(drop_q) : drop_q;
    fifo_count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
    idle_d          = (state_d == ST_IDLE) && (fifo_count_next == '0);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      last_q     <= SERVE_READ;
      rr_q       <= '0;
      timer_q    <= '0;
      bk_valid_q <= 1'b0;
      bk_msg_q   <= '0;
      grant_q    <= '0;
      drop_q     <= '0;
      error_q    <= 1'b0;
      idle_q     <= 1'b1;
    end else begin
      last_q     <= last_d;
      rr_q       <= rr_d;
      timer_q    <= timer_d;
      bk_valid_q <= bk_valid_d;
      bk_msg_q   <= bk_msg_d;
      grant_q    <= grant_d;
      drop_q     <= drop_d;
      error_q    <= error_d;
      idle_q     <= idle_d;
    end
  end

  assign o_bk_valid      = bk_valid_q;
  assign o_bk_stock_id   = bk_msg_q.stock_id;
  assign o_bk_order_type = bk_msg_q.order_type;
  assign o_bk_quantity   = bk_msg_q.quantity;
  assign o_bk_price      = bk_msg_q.price;
  assign o_bk_order_id   = bk_msg_q.order_id;
  assign o_rd_grant      = grant_q;
  assign o_idle          = idle_q;
  assign o_drop_count    = drop_q;
  assign o_error         = error_q;

endmodule

// File: tb/tb_order_book_scheduler.sv
// Directed bench for order_book_scheduler: inputs driven on the falling edge,
// outputs sampled on the falling edge, expectations hand-computed per scenario.
module tb_order_book_scheduler;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_msg_valid = 1'b0;
  logic        o_msg_ready;
  logic [1:0]  i_stock_id = '0;
  logic [1:0]  i_order_type = '0;
  logic [15:0] i_quantity = '0;
  logic [31:0] i_price = '0;
  logic [31:0] i_order_id = '0;
  logic        o_bk_valid;
  logic [1:0]  o_bk_stock_id;
  logic [1:0]  o_bk_order_type;
  logic [15:0] o_bk_quantity;
  logic [31:0] o_bk_price;
  logic [31:0] o_bk_order_id;
  logic        i_bk_busy = 1'b0;
  logic        i_bk_data_valid = 1'b0;
  logic [3:0]  i_rd_req = '0;
  logic [3:0]  o_rd_grant;
  logic        o_idle;
  logic [7:0]  o_drop_count;
  logic        o_error;

  int n_cmp = 0;
  int n_err = 0;

  order_book_scheduler #(.NUM_STOCKS(4), .FIFO_DEPTH(4), .TIMEOUT(64)) dut (
    .i_clk           (i_clk),
    .i_reset_n       (i_reset_n),
    .i_msg_valid     (i_msg_valid),
    .o_msg_ready     (o_msg_ready),
    .i_stock_id      (i_stock_id),
    .i_order_type    (i_order_type),
    .i_quantity      (i_quantity),
    .i_price         (i_price),
    .i_order_id      (i_order_id),
    .o_bk_valid      (o_bk_valid),
    .o_bk_stock_id   (o_bk_stock_id),
    .o_bk_order_type (o_bk_order_type),
    .o_bk_quantity   (o_bk_quantity),
    .o_bk_price      (o_bk_price),
    .o_bk_order_id   (o_bk_order_id),
    .i_bk_busy       (i_bk_busy),
    .i_bk_data_valid (i_bk_data_valid),
    .i_rd_req        (i_rd_req),
    .o_rd_grant      (o_rd_grant),
    .o_idle          (o_idle),
    .o_drop_count    (o_drop_count),
    .o_error         (o_error)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    i_msg_valid = 1'b0; i_stock_id = '0; i_order_type = '0; i_quantity = '0;
    i_price = '0; i_order_id = '0; i_bk_busy = 1'b0; i_bk_data_valid = 1'b0; i_rd_req = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    i_reset_n = 1'b0;
    repeat (3) @(negedge i_clk);
    i_reset_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic push_one(input logic [1:0] st, input logic [1:0] ty, input logic [15:0] q,
                          input logic [31:0] p, input logic [31:0] id);
    @(negedge i_clk);
    i_msg_valid = 1'b1; i_stock_id = st; i_order_type = ty;
    i_quantity = q; i_price = p; i_order_id = id;
    @(negedge i_clk);
    i_msg_valid = 1'b0;
  endtask

  // Waits for one book command, checks it, and optionally answers with a completion pulse.
  task automatic expect_cmd(input logic [1:0] st, input logic [1:0] ty, input logic [15:0] q,
                            input logic [31:0] p, input logic [31:0] id, input bit respond);
    bit seen = 0;
    bit grant_seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge i_clk);
      if (o_rd_grant !== 4'b0000) grant_seen = 1;
      if (o_bk_valid === 1'b1) seen = 1;
    end
    n_cmp++;
    if (!seen) begin
      n_err++; $display("FAIL cmd_strobe id=%0d: got no o_bk_valid within 40 cycles, required one", id);
    end else begin
      n_cmp++;
      if ({o_bk_stock_id, o_bk_order_type, o_bk_quantity, o_bk_price, o_bk_order_id} !== {st, ty, q, p, id}) begin
        n_err++;
        $display("FAIL cmd_fields: got st=%0d ty=%0d q=%0d p=%0d id=%0d, required st=%0d ty=%0d q=%0d p=%0d id=%0d",
                 o_bk_stock_id, o_bk_order_type, o_bk_quantity, o_bk_price, o_bk_order_id, st, ty, q, p, id);
      end
      n_cmp++;
      if (grant_seen !== 1'b0) begin
        n_err++; $display("FAIL cmd_no_grant id=%0d: got grant before command, required none", id);
      end
      @(negedge i_clk);
      n_cmp++;
      if (o_bk_valid !== 1'b0) begin
        n_err++; $display("FAIL cmd_one_cycle id=%0d: got o_bk_valid=%0b, required 0", id, o_bk_valid);
      end
      if (respond) begin
        i_bk_data_valid = 1'b1;
        @(negedge i_clk);
        i_bk_data_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    i_reset_n = 1'b0;
    repeat (2) @(negedge i_clk);
    n_cmp++; if (o_msg_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %0b required 0", o_msg_ready); end
    n_cmp++; if (o_bk_valid !== 1'b0) begin n_err++; $display("FAIL rst_bk_valid: got %0b required 0", o_bk_valid); end
    n_cmp++;
    if ({o_bk_stock_id, o_bk_order_type, o_bk_quantity, o_bk_price, o_bk_order_id} !== 84'd0) begin
      n_err++; $display("FAIL rst_bk_fields: got id=%0d price=%0d, required all zero", o_bk_order_id, o_bk_price);
    end
    n_cmp++; if (o_rd_grant !== 4'b0000) begin n_err++; $display("FAIL rst_grant: got %b required 0000", o_rd_grant); end
    n_cmp++; if (o_drop_count !== 8'd0) begin n_err++; $display("FAIL rst_drop: got %0d required 0", o_drop_count); end
    n_cmp++; if (o_error !== 1'b0) begin n_err++; $display("FAIL rst_error: got %0b required 0", o_error); end
    n_cmp++; if (o_idle !== 1'b1) begin n_err++; $display("FAIL rst_idle: got %0b required 1", o_idle); end
    i_reset_n = 1'b1;
    @(negedge i_clk);
    n_cmp++; if (o_msg_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_ready: got %0b required 1", o_msg_ready); end
    // A stray completion in IDLE must change nothing.
    i_bk_data_valid = 1'b1;
    @(negedge i_clk);
    i_bk_data_valid = 1'b0;
    @(negedge i_clk);
    n_cmp++; if (o_idle !== 1'b1) begin n_err++; $display("FAIL stray_done_idle: got %0b required 1", o_idle); end
    n_cmp++; if (o_error !== 1'b0) begin n_err++; $display("FAIL stray_done_error: got %0b required 0", o_error); end
  endtask

  task automatic test_single_add();
    do_reset();
    push_one(2'd1, 2'd0, 16'd10, 32'd100, 32'd7);
    n_cmp++; if (o_bk_valid !== 1'b0) begin n_err++; $display("FAIL add_n1_valid: got %0b required 0", o_bk_valid); end
    n_cmp++; if (o_idle !== 1'b0) begin n_err++; $display("FAIL add_n1_idle: got %0b required 0", o_idle); end
    @(negedge i_clk);
    n_cmp++; if (o_bk_valid !== 1'b1) begin n_err++; $display("FAIL add_n2_valid: got %0b required 1", o_bk_valid); end
    n_cmp++;
    if ({o_bk_stock_id, o_bk_order_type, o_bk_quantity, o_bk_price, o_bk_order_id} !== {2'd1, 2'd0, 16'd10, 32'd100, 32'd7}) begin
      n_err++; $display("FAIL add_fields: got st=%0d ty=%0d q=%0d p=%0d id=%0d, required 1 0 10 100 7",
                        o_bk_stock_id, o_bk_order_type, o_bk_quantity, o_bk_price, o_bk_order_id);
    end
    @(negedge i_clk);
    n_cmp++; if (o_bk_valid !== 1'b0) begin n_err++; $display("FAIL add_n3_valid: got %0b required 0", o_bk_valid); end
    n_cmp++; if (o_bk_order_id !== 32'd7) begin n_err++; $display("FAIL add_hold_id: got %0d required 7", o_bk_order_id); end
    i_bk_data_valid = 1'b1;
    @(negedge i_clk);
    i_bk_data_valid = 1'b0;
    n_cmp++; if (o_idle !== 1'b1) begin n_err++; $display("FAIL add_idle_after_done: got %0b required 1", o_idle); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    i_bk_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      i_msg_valid = 1'b1; i_stock_id = i[1:0]; i_order_type = 2'd0;
      i_quantity = 16'(i + 1); i_price = 32'(1000 + i); i_order_id = 32'(100 + i);
      n_cmp++;
      if (o_msg_ready !== (i < 4)) begin
        n_err++; $display("FAIL b2b_ready[%0d]: got %0b required %0b", i, o_msg_ready, (i < 4));
      end
    end
    @(negedge i_clk);
    i_msg_valid = 1'b0;
    n_cmp++; if (o_bk_valid !== 1'b0) begin n_err++; $display("FAIL b2b_busy_hold: got %0b required 0", o_bk_valid); end
    i_bk_busy = 1'b0;
    for (int i = 0; i < 4; i++)
      expect_cmd(i[1:0], 2'd0, 16'(i + 1), 32'(1000 + i), 32'(100 + i), 1'b1);
    n_cmp++; if (o_idle !== 1'b1) begin n_err++; $display("FAIL b2b_idle_end: got %0b required 1", o_idle); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [4];
    logic [3:0] got_g [4];
    int  ng = 0;
    bit  wide = 0;
    bit  prev = 0;
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b1000; exp_g[3] = 4'b0001;
    for (int i = 0; i < 4; i++) got_g[i] = '0;
    do_reset();
    i_rd_req = 4'b1011;
    for (int k = 0; k < 12; k++) begin
      @(negedge i_clk);
      if (o_rd_grant !== 4'b0000) begin
        if (prev) wide = 1;
        if (ng < 4) got_g[ng] = o_rd_grant;
        ng++;
        prev = 1;
      end else begin
        prev = 0;
      end
    end
    i_rd_req = 4'b0000;
    n_cmp++; if (ng < 4) begin n_err++; $display("FAIL rr_count: got %0d grants required at least 4", ng); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got_g[i] !== exp_g[i]) begin
        n_err++; $display("FAIL rr_grant[%0d]: got %b required %b", i, got_g[i], exp_g[i]);
      end
    end
    n_cmp++; if (wide !== 1'b0) begin n_err++; $display("FAIL rr_width: got back-to-back grants, required one-cycle grants"); end
    repeat (2) @(negedge i_clk);
  endtask

  task automatic test_alternation();
    bit got = 0;
    bit cmd_seen = 0;
    do_reset();
    i_bk_busy = 1'b1;
    push_one(2'd2, 2'd1, 16'd3, 32'd55, 32'd21);
    push_one(2'd3, 2'd2, 16'd4, 32'd66, 32'd22);
    i_rd_req = 4'b0001;
    i_bk_busy = 1'b0;
    expect_cmd(2'd2, 2'd1, 16'd3, 32'd55, 32'd21, 1'b1);
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge i_clk);
      if (o_bk_valid === 1'b1) cmd_seen = 1;
      if (o_rd_grant !== 4'b0000) got = 1;
    end
    n_cmp++; if (o_rd_grant !== 4'b0001) begin n_err++; $display("FAIL alt_grant: got %b required 0001", o_rd_grant); end
    n_cmp++; if (cmd_seen !== 1'b0) begin n_err++; $display("FAIL alt_order: got command before grant, required grant first"); end
    i_rd_req = 4'b0000;
    expect_cmd(2'd3, 2'd2, 16'd4, 32'd66, 32'd22, 1'b1);
  endtask

  task automatic test_drop();
    bit cmd_seen = 0;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      @(negedge i_clk);
      if (o_bk_valid === 1'b1) cmd_seen = 1;
      if (i == 10) begin
        n_cmp++; if (o_drop_count !== 8'd10) begin n_err++; $display("FAIL drop_10: got %0d required 10", o_drop_count); end
      end
      if (i == 299) begin
        n_cmp++; if (o_drop_count !== 8'd255) begin n_err++; $display("FAIL drop_299: got %0d required 255", o_drop_count); end
      end
      i_msg_valid = 1'b1; i_order_type = 2'd3; i_order_id = 32'(5000 + i);
    end
    @(negedge i_clk);
    i_msg_valid = 1'b0;
    @(negedge i_clk);
    n_cmp++; if (o_drop_count !== 8'd255) begin n_err++; $display("FAIL drop_sat: got %0d required 255", o_drop_count); end
    n_cmp++; if (cmd_seen !== 1'b0 || o_bk_valid !== 1'b0) begin n_err++; $display("FAIL drop_issued: got a command, required none"); end
    n_cmp++; if (o_idle !== 1'b1) begin n_err++; $display("FAIL drop_idle: got %0b required 1", o_idle); end
  endtask

  task automatic test_timeout();
    int  k = 0;
    bit  cmd_seen = 0;
    do_reset();
    push_one(2'd0, 2'd2, 16'd5, 32'd50, 32'd31);
    expect_cmd(2'd0, 2'd2, 16'd5, 32'd50, 32'd31, 1'b0);
    while (k < 200 && o_error !== 1'b1) begin
      @(negedge i_clk);
      k++;
    end
    n_cmp++; if (k !== 64) begin n_err++; $display("FAIL to_latency: got o_error after %0d cycles required 64", k); end
    n_cmp++; if (o_idle !== 1'b1) begin n_err++; $display("FAIL to_idle: got %0b required 1", o_idle); end
    repeat (3) @(negedge i_clk);
    n_cmp++; if (o_error !== 1'b1) begin n_err++; $display("FAIL to_sticky: got %0b required 1", o_error); end
    push_one(2'd1, 2'd0, 16'd1, 32'd11, 32'd41);
    push_one(2'd2, 2'd0, 16'd2, 32'd12, 32'd42);
    n_cmp++; if (o_bk_order_id !== 32'd41) begin n_err++; $display("FAIL to_inflight_id: got %0d required 41", o_bk_order_id); end
    n_cmp++; if (o_idle !== 1'b0) begin n_err++; $display("FAIL to_busy_idle: got %0b required 0", o_idle); end
    i_reset_n = 1'b0;
    #1;
    n_cmp++; if (o_error !== 1'b0) begin n_err++; $display("FAIL mid_rst_error: got %0b required 0", o_error); end
    n_cmp++; if (o_msg_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_ready: got %0b required 0", o_msg_ready); end
    n_cmp++; if (o_bk_order_id !== 32'd0) begin n_err++; $display("FAIL mid_rst_id: got %0d required 0", o_bk_order_id); end
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
    for (int j = 0; j < 12; j++) begin
      @(negedge i_clk);
      if (o_bk_valid === 1'b1) cmd_seen = 1;
    end
    n_cmp++; if (cmd_seen !== 1'b0) begin n_err++; $display("FAIL mid_rst_fifo: got a command after reset, required none"); end
    n_cmp++; if (o_idle !== 1'b1) begin n_err++; $display("FAIL mid_rst_idle: got %0b required 1", o_idle); end
    n_cmp++; if (o_error !== 1'b0) begin n_err++; $display("FAIL mid_rst_error_after: got %0b required 0", o_error); end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_round_robin();
    test_alternation();
    test_drop();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/order_book_scheduler.md
# order_book_scheduler

Sequences all traffic into and out of the order book. Parsed feed messages arrive on a valid/ready port, are buffered in a small FIFO and issued to the book one command at a time, only when the book is idle. Trading-logic read requests are arbitrated round-robin and interleaved fairly with book updates. Each grant is a one-cycle window in which the book's best bid, best ask and current price outputs are stable and owned by one requester.

## Interface
- NUM_STOCKS, 4, number of stock IDs and read requesters
- FIFO_DEPTH, 4, ingress message buffer entries (power of 2)
- TIMEOUT, 64, max cycles to wait for book completion
- i_clk  in  1  clock; all logic on rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_msg_valid  in  1  ingress message valid
- o_msg_ready  out  1  ingress can accept this cycle
- i_stock_id  in  2  message stock ID
- i_order_type  in  2  0=ADD, 1=CANCEL, 2=EXECUTE, 3=invalid
- i_quantity  in  16  order quantity
- i_price  in  32  order price
- i_order_id  in  32  order ID
- o_bk_valid  out  1  one-cycle command strobe to book
- o_bk_stock_id / o_bk_order_type / o_bk_quantity / o_bk_price / o_bk_order_id  out  2/2/16/32/32  command fields, held from strobe until next strobe
- i_bk_busy  in  1  book busy (from order book)
- i_bk_data_valid  in  1  book completion pulse
- i_rd_req  in  NUM_STOCKS  read request per requester, level
- o_rd_grant  out  NUM_STOCKS  one-hot, one-cycle read grant
- o_idle  out  1  FSM in IDLE, FIFO empty
- o_drop_count  out  8  saturating count of dropped invalid messages
- o_error  out  1  sticky book timeout flag

## Operation
- Ingress: accept on i_msg_valid && o_msg_ready.
- o_msg_ready = !fifo_full, forced 0 while i_reset_n low.
- An accepted message with type 3 is not written to the FIFO; o_drop_count increments and saturates at 255.
- FSM states:
  - IDLE: choose one action when !i_bk_busy.
    - If the FIFO is non-empty and (no i_rd_req or last_served==READ) -> ISSUE.
    - Else if any i_rd_req -> GRANT.
    - Otherwise stay in IDLE.
  - ISSUE: pop FIFO head onto o_bk_* and assert o_bk_valid; set last_served=CMD; clear timer -> WAIT.
  - WAIT: timer increments each cycle.
    - i_bk_data_valid -> IDLE.
    - Timer reaching TIMEOUT-1 without completion -> set o_error, go to IDLE.
  - GRANT: assert o_rd_grant for the first requesting index at or after rr_ptr (wrapping); rr_ptr <- granted+1 mod NUM_STOCKS; set last_served=READ -> IDLE.
- Reset values:
  - State IDLE, FIFO empty, rr_ptr=0, last_served=READ, timer=0.
  - o_bk_valid=0, all o_bk_* fields 0, o_rd_grant=0.
  - o_drop_count=0, o_error=0, o_idle=1.
- Boundaries:
  - FIFO full: ready low; a simultaneous pop in ISSUE raises ready the next cycle, not in the same cycle.
  - Push and pop in the same cycle keep the count unchanged.
  - An i_rd_req deasserted before GRANT is not granted; if no request remains, GRANT asserts nothing.
  - An i_bk_data_valid arriving outside WAIT is ignored.
  - A reset asserted mid-command discards the FIFO and the in-flight command; o_error clears only on reset.

## Timing
- Message accepted in cycle N, empty FIFO, book idle, no reads pending: o_bk_valid in N+2.
- Completion pulse in cycle M: IDLE in M+1; next ISSUE or GRANT in M+2.
- Grant latency from request in IDLE with book idle: 2 cycles (IDLE decides, GRANT asserts).
- With both traffic types pending: strict alternation CMD, READ, CMD, READ.
- All outputs are registered except o_msg_ready.

## Structure
- Shared package hft_pkg holds:
  - order_t enum (ADD=0, CANCEL=1, EXECUTE=2).
  - Width constants (PRICE_W=32, QTY_W=16, ID_W=32, STOCK_W=2).
  - Packed order_msg_t struct, also used by the order book.
- Sub-module sync_fifo, parameterised on width and depth: stores order_msg_t; provides full, empty and count.
- Scheduler FSM, round-robin arbiter and counters stay in the top module.

## Test plan
- Reset, then one ADD (stock 1, price 100, qty 10, id 7) in cycle 0 -> o_bk_valid in cycle 2 with identical fields; o_idle returns 1 after i_bk_data_valid.
- Push 5 messages back-to-back with the book held busy -> o_msg_ready low after 4 accepts; all 4 messages issued in order once the book frees.
- i_rd_req=4'b1011 held, FIFO empty -> grants in order 0001, 0010, 1000, 0001, each 1 cycle wide.
- FIFO holding 2 commands and i_rd_req=0001 -> sequence CMD, GRANT 0001, CMD.
- 300 type-3 messages -> none issued; o_drop_count saturates at 255.
- No i_bk_data_valid after ISSUE -> o_error=1 after 64 cycles and FSM returns to IDLE; reset asserted mid-WAIT clears o_error and FIFO.
